// File: rtl/omsp_spm_ctrl.sv
// rtl/omsp_spm_ctrl.sv - SPM protection-configuration sequencer
//
// Purpose: owns the committed SPM boundary registers and enable flag. Accepts
// protect/unprotect commands, loads four layout words over a valid/ready word
// channel, validates the layout and commits it atomically or reports an error.
//
// Ports:
//   mclk, puc_rst_n             clock, synchronous active-low reset
//   pc                          program counter for the unprotect caller check
//   cmd_valid/cmd_op/cmd_ready  command channel (op 0 = protect, 1 = unprotect)
//   word_valid/word_data/word_ready  layout word channel
//   cmd_done/cmd_error/err_code one-cycle result pulses and error cause
//   spm_public_start/end, spm_private_start/end, spm_enabled  committed layout
module omsp_spm_ctrl (
    input  logic        mclk,
    input  logic        puc_rst_n,
    input  logic [15:0] pc,
    input  logic        cmd_valid,
    input  logic        cmd_op,
    output logic        cmd_ready,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    output logic        word_ready,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [2:0]  err_code,
    output logic [15:0] spm_public_start,
    output logic [15:0] spm_public_end,
    output logic [15:0] spm_private_start,
    output logic [15:0] spm_private_end,
    output logic        spm_enabled
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [2:0] E_BUSY    = 3'b001;
    localparam logic [2:0] E_RANGE   = 3'b010;
    localparam logic [2:0] E_OVERLAP = 3'b011;
    localparam logic [2:0] E_NOT_EN  = 3'b100;
    localparam logic [2:0] E_CALLER  = 3'b101;

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [15:0] r_shadow [4];
    logic        r_done;
    logic        r_error;
    logic [2:0]  r_code;
    logic [15:0] r_pub_s;
    logic [15:0] r_pub_e;
    logic [15:0] r_priv_s;
    logic [15:0] r_priv_e;
    logic        r_en;

    logic        w_pub_bad;
    logic        w_priv_bad;
    logic        w_overlap;
    logic        w_pc_inside;

    // Layout validation on the shadow copy; ranges are [start, end).
    assign w_pub_bad   = r_shadow[0] >= r_shadow[1];
    assign w_priv_bad  = r_shadow[2] >= r_shadow[3];
    assign w_overlap   = (r_shadow[0] < r_shadow[3]) && (r_shadow[2] < r_shadow[1]);
    assign w_pc_inside = (pc >= r_pub_s) && (pc < r_pub_e);

    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_shadow[0] <= 16'h0000;
            r_shadow[1] <= 16'h0000;
            r_shadow[2] <= 16'h0000;
            r_shadow[3] <= 16'h0000;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_code      <= 3'b000;
            r_pub_s     <= 16'h0000;
            r_pub_e     <= 16'h0000;
            r_priv_s    <= 16'h0000;
            r_priv_e    <= 16'h0000;
            r_en        <= 1'b0;
        end else begin
            // Result pulses last only for the RESP cycle.
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_op) begin
                            if (r_en) begin
                                r_state <= S_RESP;
                                r_error <= 1'b1;
                                r_code  <= E_BUSY;
                            end else begin
                                r_state <= S_LOAD;
                                r_cnt   <= 2'd0;
                            end
                        end else begin
                            r_state <= S_RESP;
                            if (!r_en) begin
                                r_error <= 1'b1;
                                r_code  <= E_NOT_EN;
                            end else if (!w_pc_inside) begin
                                r_error <= 1'b1;
                                r_code  <= E_CALLER;
                            end else begin
                                // Clear lands on the accept edge so RESP already sees it.
                                r_done   <= 1'b1;
                                r_pub_s  <= 16'h0000;
                                r_pub_e  <= 16'h0000;
                                r_priv_s <= 16'h0000;
                                r_priv_e <= 16'h0000;
                                r_en     <= 1'b0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        r_shadow[r_cnt] <= word_data;
                        r_cnt           <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    r_state <= S_RESP;
                    if (w_pub_bad || w_priv_bad) begin
                        r_error <= 1'b1;
                        r_code  <= E_RANGE;
                    end else if (w_overlap) begin
                        r_error <= 1'b1;
                        r_code  <= E_OVERLAP;
                    end else begin
                        r_done   <= 1'b1;
                        r_pub_s  <= r_shadow[0];
                        r_pub_e  <= r_shadow[1];
                        r_priv_s <= r_shadow[2];
                        r_priv_e <= r_shadow[3];
                        r_en     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready         = (r_state == S_IDLE);
    assign word_ready        = (r_state == S_LOAD);
    assign cmd_done          = r_done;
    assign cmd_error         = r_error;
    assign err_code          = r_code;
    assign spm_public_start  = r_pub_s;
    assign spm_public_end    = r_pub_e;
    assign spm_private_start = r_priv_s;
    assign spm_private_end   = r_priv_e;
    assign spm_enabled       = r_en;

endmodule
